led_multi_driver: RTL and testbench
===================================

Name: led_multi_driver

Overview:
Parametrised multi-channel LED driver for board status LEDs. It generalises the single free-running-counter blinker into NUM_LEDS independent channels. Each channel is configured through a valid/ready write port with one of four modes: off, steady PWM, blink, or breathe. A global switch input gates all activity, and every output is registered.

Parameters:
NUM_LEDS, 4, number of LED channels (1..16)
TICK_DIV, 100000, board_clk cycles per slow tick (1 kHz at 100 MHz), must be >= 2
PWM_BITS, 8, width of PWM counter and per-channel duty
BLINK_BITS, 10, width of blink half-period (in ticks)

Ports:
board_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
switch  in  1  global run enable; 0 = freeze timebases and force LEDs off
cfg_valid  in  1  config write request
cfg_ready  out  1  config port can accept a write
cfg_ch  in  4  target channel index
cfg_mode  in  2  00 off, 01 steady, 10 blink, 11 breathe
cfg_duty  in  PWM_BITS  channel brightness
cfg_err  out  1  one-cycle pulse: write to channel >= NUM_LEDS
blink_half  in  BLINK_BITS  blink half-period in ticks, shared by all channels
led  out  NUM_LEDS  LED drive, bit i = channel i

Behaviour:
- Reset (sync, wins over every other input): all modes = 00, all duties = 0, prescaler = 0, pwm_cnt = 0, blink_cnt = 0, blink_phase = 0, breathe level = 0, breathe direction = up, led = 0, cfg_err = 0, cfg_ready = 0.
- cfg_ready is registered. It is 0 on the edge where reset is high and 1 from the first edge with reset low.
- Config handshake: a write is accepted when cfg_valid && cfg_ready at a rising edge.
  - cfg_ch < NUM_LEDS: the channel's mode and duty registers update at that edge.
  - Otherwise nothing is written and cfg_err = 1 for the following cycle only.
  - Back-to-back writes on consecutive cycles are allowed. Writes are accepted even when switch = 0.
- Prescaler, when switch = 1: counts 0..TICK_DIV-1, wraps to 0. The internal tick is high for the one cycle in which the prescaler = TICK_DIV-1.
- pwm_cnt, when switch = 1: PWM_BITS wide, increments every cycle, wraps naturally.
- Blink, on each tick:
  - blink_cnt increments.
  - When blink_cnt >= max(blink_half,1)-1, blink_cnt goes to 0 and blink_phase toggles.
  - blink_half = 0 is treated as 1.
  - Lowering blink_half mid-period causes a wrap at the next tick.
- Breathe, on each tick: level moves one step in the current direction. Direction flips to down on reaching all-ones and to up on reaching 0. Each endpoint is held for exactly one tick.
- Effective duty d per channel:
  - off: d = 0
  - steady: d = duty
  - blink: d = duty if blink_phase = 1, else 0
  - breathe: d = min(level, duty)
- Compare: on = (d == all-ones) ? 1 : (pwm_cnt < d). d = 0 gives never on; all-ones gives always on.
- led[i] is registered from the compare, so there is 1 cycle of latency from pwm_cnt/config state to the pin. A config write at edge N is visible on led at edge N+1.
- switch = 0: prescaler, pwm_cnt, blink and breathe state hold their values, and led is registered to all 0. On switch returning to 1, counting resumes from the held values.
- A config write to a channel mid-blink or mid-breathe does not reset the shared timebases.

Test Plan:
All tests use NUM_LEDS=4, TICK_DIV=4, PWM_BITS=4, BLINK_BITS=4.
- Reset: assert reset 3 cycles with cfg_valid=1 -> led=0000, cfg_ready=0, cfg_err=0, no channel written; first cycle after release cfg_ready=1.
- Steady PWM: ch0 steady duty=4 -> led[0] high exactly 4 of every 16 cycles. duty=15 -> led[0] constant 1. duty=0 -> constant 0.
- Blink: ch1 blink duty=15, blink_half=2 -> led[1] alternates 8 cycles on / 8 cycles off (2 ticks x 4 cycles). Change blink_half to 1 mid-period -> phase toggles at next tick.
- Breathe: ch2 breathe duty=15 -> level sequence 0,1,..,15,14,..,0,1 per tick; high-time per 16-cycle PWM window matches level (15 = constant on). With duty=8, level is clamped at 8.
- Bad channel / back-to-back: cfg_ch=7 -> cfg_err pulse 1 cycle, all configs unchanged. Writes to ch0 then ch3 on consecutive cycles -> both applied.
- Switch gating: switch=0 for 20 cycles during blink -> led=0000, blink_cnt/phase frozen. switch=1 -> blink resumes with the remaining half-period.

Source files
------------

// File: rtl/led_multi_driver.sv
// led_multi_driver: NUM_LEDS independent status-LED channels sharing one
// prescaler, PWM counter, blink phase and breathe ramp. Each channel holds a
// mode/duty pair written through a valid/ready port; all outputs registered.

// One LED channel: config registers, effective-duty select, PWM compare.
module led_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                board_clk,
    input  logic                reset,
    input  logic                switch,
    input  logic                wr_en,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                blink_phase,
    input  logic [PWM_BITS-1:0] breathe_level,
    output logic                led
);
    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STEADY  = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] eff_duty;
    logic                on;

    // Channel config registers, loaded on an accepted write for this channel.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            mode <= MODE_OFF;
            duty <= '0;
        end else if (wr_en) begin
            mode <= wr_mode;
            duty <= wr_duty;
        end
    end

    // Pick effective duty from mode; all-ones duty is forced fully on so the
    // strict compare does not leave a one-count gap in every PWM period.
    always_comb begin
        eff_duty = '0;
        case (mode)
            MODE_STEADY:  eff_duty = duty;
            MODE_BLINK:   eff_duty = blink_phase ? duty : '0;
            MODE_BREATHE: eff_duty = (breathe_level < duty) ? breathe_level : duty;
            default:      eff_duty = '0;
        endcase
        on = (eff_duty == '1) ? 1'b1 : (pwm_cnt < eff_duty);
    end

    // Registered pin drive; switch low forces the LED dark.
    always_ff @(posedge board_clk) begin
        if (reset) led <= 1'b0;
        else       led <= switch ? on : 1'b0;
    end
endmodule

module led_multi_driver #(
    parameter int NUM_LEDS   = 4,
    parameter int TICK_DIV   = 100000,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 10
) (
    input  logic                  board_clk,
    input  logic                  reset,
    input  logic                  switch,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PWM_BITS-1:0]   cfg_duty,
    output logic                  cfg_err,
    input  logic [BLINK_BITS-1:0] blink_half,
    output logic [NUM_LEDS-1:0]   led
);
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_TOP = '1;

    logic [PRE_W-1:0]      prescaler;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [BLINK_BITS-1:0] half_eff;
    logic                  blink_phase;
    logic [PWM_BITS-1:0]   breathe_level;
    logic                  breathe_up;
    logic                  tick;
    logic                  cfg_acc;
    logic                  ch_ok;
    logic [NUM_LEDS-1:0]   lane_wr;

    assign cfg_acc  = cfg_valid && cfg_ready;
    assign ch_ok    = ({1'b0, cfg_ch} < 5'(NUM_LEDS));
    assign tick     = switch && (prescaler == PRE_LAST);
    // A zero half-period would never wrap; treat it as one tick.
    assign half_eff = (blink_half == '0) ? BLINK_BITS'(1) : blink_half;

    // Config port status: ready after reset, error pulse for a bad channel.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_acc && !ch_ok;
        end
    end

    // Shared timebases: prescaler and PWM counter, frozen while switch is low.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (switch) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Blink phase: >= compare so a lowered half-period wraps on the next tick.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt >= half_eff - BLINK_BITS'(1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_BITS'(1);
            end
        end
    end

    // Breathe ramp: turn around as an endpoint is reached so each endpoint
    // lasts exactly one tick.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            breathe_level <= '0;
            breathe_up    <= 1'b1;
        end else if (tick) begin
            if (breathe_up) begin
                breathe_level <= breathe_level + PWM_BITS'(1);
                if (breathe_level == LVL_TOP - PWM_BITS'(1)) breathe_up <= 1'b0;
            end else begin
                breathe_level <= breathe_level - PWM_BITS'(1);
                if (breathe_level == PWM_BITS'(1)) breathe_up <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
        assign lane_wr[i] = cfg_acc && ch_ok && (cfg_ch == 4'(i));

        led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .board_clk     (board_clk),
            .reset         (reset),
            .switch        (switch),
            .wr_en         (lane_wr[i]),
            .wr_mode       (cfg_mode),
            .wr_duty       (cfg_duty),
            .pwm_cnt       (pwm_cnt),
            .blink_phase   (blink_phase),
            .breathe_level (breathe_level),
            .led           (led[i])
        );
    end
endmodule

// File: tb/tb_led_multi_driver.sv
// Directed bench for led_multi_driver with a tiny timebase (TICK_DIV=4,
// 4-bit PWM) so every period is a handful of cycles.
module tb_led_multi_driver;
    localparam int NL = 4;
    localparam int TD = 4;
    localparam int PB = 4;
    localparam int BB = 4;

    logic          board_clk = 1'b0;
    logic          reset = 1'b1;
    logic          switch = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [3:0]    cfg_ch = 4'd0;
    logic [1:0]    cfg_mode = 2'b00;
    logic [PB-1:0] cfg_duty = '0;
    logic          cfg_err;
    logic [BB-1:0] blink_half = 4'd2;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;
    int cyc = 0;  // edges with reset low and switch high

    typedef struct {
        logic [1:0] mode;
        int         duty;
        int         exp_hi;
    } vec_t;
    vec_t vecs[6];

    led_multi_driver #(.NUM_LEDS(NL), .TICK_DIV(TD), .PWM_BITS(PB), .BLINK_BITS(BB)) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .switch     (switch),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .blink_half (blink_half),
        .led        (led)
    );

    always #5 board_clk = ~board_clk;

    always @(posedge board_clk) if (!reset && switch) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] m, input int d);
        @(negedge board_clk);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_mode  = m;
        cfg_duty  = PB'(d);
        @(posedge board_clk);
        @(negedge board_clk);
        cfg_valid = 1'b0;
    endtask

    // Count consecutive samples (starting now) where led[b] == val.
    task automatic run_len(input int b, input logic val, output int len);
        len = 0;
        while (led[b] == val && len < 64) begin
            len++;
            @(negedge board_clk);
        end
    endtask

    task automatic wait_val(input int b, input logic val, output int ok);
        ok = 0;
        for (int n = 0; n < 64 && ok == 0; n++) begin
            if (led[b] == val) ok = 1;
            else @(negedge board_clk);
        end
    endtask

    function automatic int tri_lvl(input int n);
        int m;
        m = n % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction

    // Breathe channel 2 against a closed-form timeline: after k counted
    // edges prescaler = k%4, pwm = k%16, ticks so far = k/4.
    task automatic breathe_window(input int duty, input string name);
        int k, p, lv, d, mism;
        logic e;
        mism = 0;
        for (int s = 0; s < 130; s++) begin
            k  = cyc - 1;
            p  = k % 16;
            lv = tri_lvl(k / 4);
            d  = (lv < duty) ? lv : duty;
            e  = (d == 15) ? 1'b1 : (p < d);
            if (led[2] != e) mism++;
            @(negedge board_clk);
        end
        chk(name, mism, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int hi, hi3, ok, len, bad;

        vecs[0] = '{2'b01, 4, 4};
        vecs[1] = '{2'b01, 15, 16};
        vecs[2] = '{2'b01, 0, 0};
        vecs[3] = '{2'b01, 9, 9};
        vecs[4] = '{2'b01, 1, 1};
        vecs[5] = '{2'b00, 9, 0};

        // Reset with a pending write: nothing may be written.
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_mode = 2'b01; cfg_duty = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(negedge board_clk);
            chk("rst_led", int'(led), 0);
            chk("rst_ready", int'(cfg_ready), 0);
            chk("rst_err", int'(cfg_err), 0);
        end
        reset = 1'b0;
        @(negedge board_clk);
        chk("ready_after_rst", int'(cfg_ready), 1);
        chk("led_after_rst", int'(led), 0);
        cfg_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (led != '0) hi++;
            @(negedge board_clk);
        end
        chk("rst_no_write", hi, 0);

        // Steady / off table on channel 0: any 16-cycle window sweeps pwm once.
        foreach (vecs[i]) begin
            cfg_write(0, vecs[i].mode, vecs[i].duty);
            @(negedge board_clk);
            hi = 0;
            for (int j = 0; j < 16; j++) begin
                hi += int'(led[0]);
                @(negedge board_clk);
            end
            chk($sformatf("steady_m%0d_d%0d", vecs[i].mode, vecs[i].duty), hi, vecs[i].exp_hi);
        end

        // Write at edge N shows on led at edge N+1.
        cfg_write(0, 2'b00, 0);
        @(negedge board_clk);
        cfg_write(0, 2'b01, 15);
        chk("lat_old", int'(led[0]), 0);
        chk("good_no_err", int'(cfg_err), 0);
        @(negedge board_clk);
        chk("lat_new", int'(led[0]), 1);

        // Bad channel: error pulse, no channel (esp. 3 = 7 mod 4) disturbed.
        cfg_write(7, 2'b01, 15);
        chk("bad_err_pulse", int'(cfg_err), 1);
        @(negedge board_clk);
        chk("bad_err_clear", int'(cfg_err), 0);
        hi = 0; hi3 = 0;
        for (int j = 0; j < 16; j++) begin
            hi  += int'(led[0]);
            hi3 += int'(led[3]);
            @(negedge board_clk);
        end
        chk("bad_ch0_kept", hi, 16);
        chk("bad_ch3_untouched", hi3, 0);

        // Back-to-back writes to ch0 then ch3.
        @(negedge board_clk);
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_mode = 2'b01; cfg_duty = 4'd4;
        @(posedge board_clk);
        @(negedge board_clk);
        cfg_ch = 4'd3; cfg_mode = 2'b01; cfg_duty = 4'd15;
        @(posedge board_clk);
        @(negedge board_clk);
        cfg_valid = 1'b0;
        @(negedge board_clk);
        hi = 0; hi3 = 0;
        for (int j = 0; j < 16; j++) begin
            hi  += int'(led[0]);
            hi3 += int'(led[3]);
            @(negedge board_clk);
        end
        chk("b2b_ch0", hi, 4);
        chk("b2b_ch3", hi3, 16);

        // Blink on ch1, half = 2 ticks = 8 cycles; then shorten mid-period.
        cfg_write(1, 2'b10, 15);
        wait_val(1, 1'b0, ok);
        chk("blink_find_low", ok, 1);
        wait_val(1, 1'b1, ok);
        chk("blink_find_rise", ok, 1);
        run_len(1, 1'b1, len);
        chk("blink_on8", len, 8);
        run_len(1, 1'b0, len);
        chk("blink_off8", len, 8);
        blink_half = 4'd1;
        run_len(1, 1'b1, len);
        chk("blink_short_on", len, 4);
        run_len(1, 1'b0, len);
        chk("blink_short_off", len, 4);

        // Breathe on ch2 with full and clamped duty.
        blink_half = 4'd2;
        cfg_write(2, 2'b11, 15);
        repeat (2) @(negedge board_clk);
        breathe_window(15, "breathe_d15");
        cfg_write(2, 2'b11, 8);
        repeat (2) @(negedge board_clk);
        breathe_window(8, "breathe_d8");

        // Switch gating in the middle of a blink on-run.
        wait_val(1, 1'b0, ok);
        chk("gate_find_low", ok, 1);
        wait_val(1, 1'b1, ok);
        chk("gate_find_rise", ok, 1);
        @(negedge board_clk);
        @(negedge board_clk);
        chk("gate_pre_on", int'(led[1]), 1);
        switch = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge board_clk);
            if (led != '0) bad++;
            if (i == 5) begin
                chk("gate_ready", int'(cfg_ready), 1);
                cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_mode = 2'b01; cfg_duty = 4'd15;
            end
            if (i == 6) cfg_valid = 1'b0;
        end
        chk("gate_led_dark", bad, 0);
        switch = 1'b1;
        @(negedge board_clk);
        chk("gate_write_applied", int'(led[2]), 1);
        run_len(1, 1'b1, len);
        chk("gate_resume_on", len, 5);
        run_len(1, 1'b0, len);
        chk("gate_resume_off", len, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
